// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The request side holds req/addr steady until the cycle the response side raises ready.
interface if_stage_if #(
  parameter int WIDTH = 32
) ();
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register. Owns the fetch PC, drains
// redirected in-flight requests and buffers a response that arrives during a stall.
module if_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = 'h13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             pcsrcE,
  input  logic             jalrE,
  input  logic [WIDTH-1:0] pctargetE,
  input  logic [WIDTH-1:0] aluresultE,
  if_stage_if.master       imem,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] pcD,
  output logic [WIDTH-1:0] pcplus4D,
  output logic             validD
);

  typedef enum logic [1:0] {FETCH, DRAIN, BUF} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pcf_q, pcf_d;
  logic [WIDTH-1:0] redir_q, redir_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] instrd_q, instrd_d;
  logic [WIDTH-1:0] pcd_q, pcd_d;
  logic [WIDTH-1:0] pcplus4d_q, pcplus4d_d;
  logic             validd_q, validd_d;

  logic             req;
  logic             deliver;
  logic [WIDTH-1:0] dlv_instr;
  logic [WIDTH-1:0] target;

  // jalr clears bit 0 of the computed address.
  assign target = jalrE ? (aluresultE & ~WIDTH'(1)) : pctargetE;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    redir_d   = redir_q;
    buf_d     = buf_q;
    req       = 1'b0;
    deliver   = 1'b0;
    dlv_instr = buf_q;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (pcsrcE) begin
          if (imem.imem_ready) begin
            pcf_d = target;
          end else begin
            redir_d = target;
            state_d = DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (!stallD) begin
            deliver   = 1'b1;
            dlv_instr = imem.imem_rdata;
            pcf_d     = pcf_q + WIDTH'(4);
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = BUF;
          end
        end
      end
      DRAIN: begin
        // The old request must complete before the redirected fetch can start.
        req = 1'b1;
        if (pcsrcE) redir_d = target;
        if (imem.imem_ready) begin
          pcf_d   = pcsrcE ? target : redir_q;
          state_d = FETCH;
        end
      end
      BUF: begin
        if (pcsrcE) begin
          pcf_d   = target;
          state_d = FETCH;
        end else if (!stallD) begin
          deliver = 1'b1;
          pcf_d   = pcf_q + WIDTH'(4);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (flushD) begin
      instrd_d   = NOP;
      pcd_d      = '0;
      pcplus4d_d = '0;
      validd_d   = 1'b0;
    end else if (!stallD) begin
      instrd_d   = deliver ? dlv_instr : NOP;
      pcd_d      = deliver ? pcf_q : '0;
      pcplus4d_d = deliver ? pcf_q + WIDTH'(4) : '0;
      validd_d   = deliver;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking is reserved for always_comb.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pcf_q      <= RESET_PC;
      redir_q    <= '0;
      instrd_q   <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      redir_q    <= redir_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

  // NOTE: the buffer is only read in BUF, which reset never selects, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign imem.imem_req  = rst_n & req;
  assign imem.imem_addr = pcf_q;

  assign instrD   = instrd_q;
  assign pcD      = pcd_q;
  assign pcplus4D = pcplus4d_q;
  assign validD   = validd_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: an imem model with programmable latency, a scoreboard
// of expected IF/ID deliveries, and a handshake-stability monitor.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n, stallD, flushD, pcsrcE, jalrE;
  logic [31:0] pctargetE, aluresultE;
  logic [31:0] instrD, pcD, pcplus4D;
  logic        validD;

  int checks = 0;
  int errors = 0;
  int lat    = 0;
  int wait_cnt = 0;
  logic [31:0] exp_q[$];
  logic        held_q = 1'b0;
  logic        pend_q = 1'b0;
  logic [31:0] paddr_q = '0;

  if_stage_if #(.WIDTH(32)) imem ();

  if_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .stallD(stallD), .flushD(flushD),
    .pcsrcE(pcsrcE), .jalrE(jalrE), .pctargetE(pctargetE), .aluresultE(aluresultE),
    .imem(imem.master),
    .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD)
  );

  always #5 clk = ~clk;

  // imem model: ready after lat wait cycles, data derived from the address.
  assign imem.imem_ready = imem.imem_req && (wait_cnt >= lat);
  assign imem.imem_rdata = imem.imem_addr ^ PAT;
  always @(posedge clk) begin
    if (!imem.imem_req || imem.imem_ready) wait_cnt <= 0;
    else                                   wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a new IF/ID entry is one with validD=1 that was not a stall hold.
  always @(posedge clk) held_q <= rst_n && stallD && !flushD;
  always @(negedge clk) begin
    logic [31:0] e;
    if (validD === 1'b1 && !held_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected pcD=%h expected=none", pcD);
      end else begin
        e = exp_q.pop_front();
        check("sb_pcD", pcD, e);
        check("sb_instrD", instrD, e ^ PAT);
        check("sb_pcplus4D", pcplus4D, e + 32'd4);
      end
    end
  end

  // Handshake monitor: a request not accepted must be presented unchanged next cycle.
  always @(posedge clk) begin
    pend_q  <= imem.imem_req && !imem.imem_ready;
    paddr_q <= imem.imem_addr;
  end
  always @(negedge clk) begin
    if (pend_q && rst_n) begin
      check("hs_req_held", {31'b0, imem.imem_req}, 32'd1);
      check("hs_addr_held", imem.imem_addr, paddr_q);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stallD = 1'b0; flushD = 1'b0; pcsrcE = 1'b0; jalrE = 1'b0;
    pctargetE = '0; aluresultE = '0; lat = 0;

    // Reset state, then back-to-back fetch with ready always high.
    step(); step();
    @(negedge clk);
    check("rst_validD", {31'b0, validD}, 32'd0);
    check("rst_instrD", instrD, NOP);
    check("rst_pcD", pcD, 32'h0);
    check("rst_pcplus4D", pcplus4D, 32'h0);
    check("rst_req", {31'b0, imem.imem_req}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'(4 * i));
      @(negedge clk);
      check("p1_req", {31'b0, imem.imem_req}, 32'd1);
      check("p1_addr", imem.imem_addr, 32'(4 * i));
      step();
    end

    // Three wait cycles per request.
    rst_n = 1'b0; lat = 3;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'(4 * k));
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check("p2_addr", imem.imem_addr, 32'(4 * k));
        if (j > 0) begin
          check("p2_wait_validD", {31'b0, validD}, 32'd0);
          check("p2_wait_instrD", instrD, NOP);
        end
        step();
      end
    end

    // Stall into BUF, redirect into DRAIN, jalr, wrap, reset during DRAIN.
    rst_n = 1'b0; lat = 0;
    step();
    rst_n = 1'b1;
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);  exp_q.push_back(32'hC);
    exp_q.push_back(32'h40); exp_q.push_back(32'h100);
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    @(negedge clk); check("c0_addr", imem.imem_addr, 32'h0); step();
    @(negedge clk); check("c1_addr", imem.imem_addr, 32'h4); step();
    stallD = 1'b1;
    @(negedge clk); check("c2_addr", imem.imem_addr, 32'h8); step();
    @(negedge clk);
    check("buf_req", {31'b0, imem.imem_req}, 32'd0);
    check("buf_instrD_held", instrD, 32'h4 ^ PAT);
    check("buf_pcD_held", pcD, 32'h4);
    check("buf_validD_held", {31'b0, validD}, 32'd1);
    step();
    stallD = 1'b0;
    @(negedge clk);
    check("buf2_req", {31'b0, imem.imem_req}, 32'd0);
    check("buf2_instrD_held", instrD, 32'h4 ^ PAT);
    step();
    @(negedge clk);
    check("c5_addr", imem.imem_addr, 32'hC);
    check("c5_pcD", pcD, 32'h8);
    step();
    lat = 2; pcsrcE = 1'b1; pctargetE = 32'h40; flushD = 1'b1;
    @(negedge clk); check("c6_addr", imem.imem_addr, 32'h10); step();
    pcsrcE = 1'b0; flushD = 1'b0;
    @(negedge clk);
    check("drain_addr", imem.imem_addr, 32'h10);
    check("drain_validD", {31'b0, validD}, 32'd0);
    step();
    @(negedge clk);
    check("drain2_addr", imem.imem_addr, 32'h10);
    check("drain2_validD", {31'b0, validD}, 32'd0);
    step();
    lat = 0;
    @(negedge clk);
    check("redir_addr", imem.imem_addr, 32'h40);
    check("redir_validD", {31'b0, validD}, 32'd0);
    step();
    pcsrcE = 1'b1; jalrE = 1'b1; aluresultE = 32'h101; flushD = 1'b1; stallD = 1'b1;
    @(negedge clk); check("c10_addr", imem.imem_addr, 32'h44); step();
    pcsrcE = 1'b0; jalrE = 1'b0; flushD = 1'b0; stallD = 1'b0;
    @(negedge clk);
    check("jalr_addr", imem.imem_addr, 32'h100);
    check("flush_validD", {31'b0, validD}, 32'd0);
    check("flush_instrD", instrD, NOP);
    check("flush_pcD", pcD, 32'h0);
    step();
    pcsrcE = 1'b1; pctargetE = 32'hFFFF_FFFC; flushD = 1'b1;
    @(negedge clk); check("c12_addr", imem.imem_addr, 32'h104); step();
    pcsrcE = 1'b0; flushD = 1'b0;
    @(negedge clk); check("wrap_pre_addr", imem.imem_addr, 32'hFFFF_FFFC); step();
    @(negedge clk);
    check("wrap_addr", imem.imem_addr, 32'h0);
    check("wrap_pcplus4D", pcplus4D, 32'h0);
    step();
    lat = 5; pcsrcE = 1'b1; pctargetE = 32'h200;
    @(negedge clk); check("c15_addr", imem.imem_addr, 32'h4); step();
    pcsrcE = 1'b0;
    @(negedge clk);
    check("drain3_req", {31'b0, imem.imem_req}, 32'd1);
    check("drain3_addr", imem.imem_addr, 32'h4);
    step();
    rst_n = 1'b0;
    @(negedge clk); check("rst_drain_req", {31'b0, imem.imem_req}, 32'd0); step();
    @(negedge clk);
    check("rst2_validD", {31'b0, validD}, 32'd0);
    check("rst2_instrD", instrD, NOP);
    check("rst2_pcD", pcD, 32'h0);
    check("rst2_pcplus4D", pcplus4D, 32'h0);
    check("rst2_req", {31'b0, imem.imem_req}, 32'd0);
    step();
    rst_n = 1'b1; lat = 0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    @(negedge clk);
    check("rel_req", {31'b0, imem.imem_req}, 32'd1);
    check("rel_addr", imem.imem_addr, 32'h0);
    step();
    @(negedge clk); check("rel2_addr", imem.imem_addr, 32'h4); step();
    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
